// File: rtl/parallel_borrow_down_counter.sv
// parallel_borrow_down_counter
// Loadable synchronous down-counter built from T-type bit cells with a
// parallel (lookahead) borrow network. A value is loaded, counted down to
// zero under the enable T, and completion is reported through busy/done.
// All state changes happen on the falling edge of clock. An asynchronous
// active-low reset clears everything immediately.
// WRAP=0 stops at zero (one-shot). WRAP=1 reloads the latched value after
// zero, so the period is reload+1 enabled edges.
module parallel_borrow_down_counter #(
    parameter int WIDTH = 4,
    parameter int WRAP  = 0
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             T,
    output logic [WIDTH-1:0] Q,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic             WRAP_EN = (WRAP != 0);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Mask that selects bits [i-1:0]; an empty mask for bit 0 makes tog_0 = T.
    function automatic logic [WIDTH-1:0] low_mask(input int i);
        low_mask = (ONE << i) - ONE;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] tog_s;
    logic [WIDTH-1:0] q_dec_s;
    logic             q_zero_s;
    logic             q_one_s;

    // Parallel borrow: each bit toggles when T is high and every lower bit is zero.
    always_comb begin
        tog_s = ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            tog_s[i] = T & ((q_q & low_mask(i)) == ZERO);
        end
    end

    // Decrement through the T-cells, plus the zero/one detectors used by the FSM.
    always_comb begin
        q_dec_s  = q_q ^ tog_s;
        q_zero_s = (q_q == ZERO);
        q_one_s  = (q_q == ONE);
    end

    // State and datapath registers; asynchronous clear, falling-edge update.
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q  <= ST_IDLE;
            q_q      <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: load beats count beats hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            if (din == ZERO) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (T && !WRAP_EN && (q_one_s || q_zero_s)) begin
                        // Without wrap, reaching zero ends the run.
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and flag updates for the coming edge.
    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = done_q;
        if (load) begin
            q_d      = din;
            reload_d = din;
            done_d   = (din == ZERO);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    q_d    = q_q;
                    done_d = 1'b0;
                end
                ST_RUN: begin
                    // In RUN done is only ever a one-edge pulse.
                    done_d = 1'b0;
                    if (T) begin
                        if (q_zero_s) begin
                            if (WRAP_EN) begin
                                q_d = reload_q;
                            end else begin
                                // Unreachable in one-shot mode; park safely at zero.
                                q_d    = ZERO;
                                done_d = 1'b1;
                            end
                        end else if (q_one_s) begin
                            q_d    = q_dec_s;
                            done_d = 1'b1;
                        end else begin
                            q_d = q_dec_s;
                        end
                    end else begin
                        q_d = q_q;
                    end
                end
                ST_DONE: begin
                    // Holding at zero here is what prevents underflow to all-ones.
                    q_d    = q_q;
                    done_d = 1'b1;
                end
                default: begin
                    q_d    = ZERO;
                    done_d = 1'b0;
                end
            endcase
        end
    end

    // Busy is registered from the next state so it lines up with Q.
    always_comb begin
        busy_d = (state_d == ST_RUN);
    end

    // Output drive; bout is the combinational borrow for the next slice.
    always_comb begin
        Q    = q_q;
        busy = busy_q;
        done = done_q;
        bout = T & q_zero_s;
    end

endmodule

// File: tb/tb_parallel_borrow_down_counter.sv
// Testbench for parallel_borrow_down_counter: a one-shot (WRAP=0) and a
// periodic (WRAP=1) instance share stimulus; each is compared against an
// arithmetic reference model after every falling edge.
module tb_parallel_borrow_down_counter;

    logic       clock;
    logic       reset_;
    logic       load;
    logic [3:0] din;
    logic       T;
    logic [3:0] q0, q1;
    logic       bout0, bout1, busy0, busy1, done0, done1;

    int n_checks;
    int n_fail;

    // Reference model state, index 0 = one-shot, 1 = periodic.
    int m_q[2];
    int m_rl[2];
    bit m_run[2];
    bit m_done[2];

    parallel_borrow_down_counter #(.WIDTH(4), .WRAP(0)) dut0 (
        .clock(clock), .reset_(reset_), .load(load), .din(din), .T(T),
        .Q(q0), .bout(bout0), .busy(busy0), .done(done0)
    );

    parallel_borrow_down_counter #(.WIDTH(4), .WRAP(1)) dut1 (
        .clock(clock), .reset_(reset_), .load(load), .din(din), .T(T),
        .Q(q1), .bout(bout1), .busy(busy1), .done(done1)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_q[w] = 0; m_rl[w] = 0; m_run[w] = 1'b0; m_done[w] = 1'b0;
        end
    endtask

    // One falling edge of the behavioural model using the held inputs.
    task automatic model_edge();
        for (int w = 0; w < 2; w++) begin
            if (load) begin
                m_q[w]  = int'(din);
                m_rl[w] = int'(din);
                m_run[w]  = (din != 4'd0);
                m_done[w] = (din == 4'd0);
            end else if (m_run[w]) begin
                m_done[w] = 1'b0;
                if (T) begin
                    if (m_q[w] == 0) begin
                        m_q[w] = m_rl[w];
                    end else if (m_q[w] == 1) begin
                        m_q[w] = 0;
                        m_done[w] = 1'b1;
                        if (w == 0) m_run[w] = 1'b0;
                    end else begin
                        m_q[w] = m_q[w] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string s);
        check({s, ".q0"},    int'(q0),    m_q[0]);
        check({s, ".busy0"}, int'(busy0), int'(m_run[0]));
        check({s, ".done0"}, int'(done0), int'(m_done[0]));
        check({s, ".bout0"}, int'(bout0), int'(T && (m_q[0] == 0)));
        check({s, ".q1"},    int'(q1),    m_q[1]);
        check({s, ".busy1"}, int'(busy1), int'(m_run[1]));
        check({s, ".done1"}, int'(done1), int'(m_done[1]));
        check({s, ".bout1"}, int'(bout1), int'(T && (m_q[1] == 0)));
    endtask

    // Apply inputs mid-cycle, take one falling edge, then compare.
    task automatic step(input string s, input logic ld, input logic [3:0] d, input logic t);
        load = ld; din = d; T = t;
        @(negedge clock);
        if (reset_) model_edge();
        #1;
        check_all(s);
    endtask

    int seq1[10] = '{4, 3, 2, 1, 0, 0, 0, 0, 0, 0};
    int seq6[6]  = '{1, 0, 2, 1, 0, 2};

    initial begin
        n_checks = 0; n_fail = 0;
        reset_ = 1'b0; load = 1'b0; din = 4'd0; T = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clock); #1;
        check_all("reset_hold");
        reset_ = 1'b1;

        // One-shot count from 5 with T held high.
        step("t1_load", 1'b1, 4'd5, 1'b1);
        check("t1.q_after_load", int'(q0), 5);
        for (int k = 0; k < 10; k++) begin
            step("t1", 1'b0, 4'd0, 1'b1);
            check("t1.q_seq", int'(q0), seq1[k]);
            check("t1.busy_seq", int'(busy0), int'(seq1[k] != 0));
            check("t1.done_seq", int'(done0), int'(seq1[k] == 0));
        end

        // Enable gating.
        step("t2_load", 1'b1, 4'd9, 1'b1);
        step("t2", 1'b0, 4'd0, 1'b1);
        step("t2", 1'b0, 4'd0, 1'b1);
        check("t2.q7", int'(q0), 7);
        for (int k = 0; k < 3; k++) step("t2_hold", 1'b0, 4'd0, 1'b0);
        check("t2.q_held", int'(q0), 7);
        step("t2", 1'b0, 4'd0, 1'b1);
        check("t2.q6", int'(q0), 6);
        step("t2", 1'b0, 4'd0, 1'b1);
        check("t2.q5", int'(q0), 5);

        // Zero load: immediate DONE, no underflow.
        step("t3_load", 1'b1, 4'd0, 1'b1);
        check("t3.done", int'(done0), 1);
        check("t3.busy", int'(busy0), 0);
        for (int k = 0; k < 3; k++) step("t3", 1'b0, 4'd0, 1'b1);
        check("t3.q_no_underflow", int'(q0), 0);
        check("t3.done1_held", int'(done1), 1);

        // Reload mid-run.
        step("t4_load", 1'b1, 4'd12, 1'b1);
        step("t4", 1'b0, 4'd0, 1'b1);
        step("t4", 1'b0, 4'd0, 1'b1);
        check("t4.q10", int'(q0), 10);
        step("t4_reload", 1'b1, 4'd3, 1'b1);
        check("t4.q3", int'(q0), 3);
        check("t4.busy", int'(busy0), 1);
        check("t4.done", int'(done0), 0);
        step("t4", 1'b0, 4'd0, 1'b1);
        check("t4.q2", int'(q0), 2);

        // Asynchronous reset between edges.
        step("t5_load", 1'b1, 4'd9, 1'b1);
        for (int k = 0; k < 3; k++) step("t5", 1'b0, 4'd0, 1'b1);
        #2 reset_ = 1'b0;
        model_reset();
        #1;
        check_all("t5_async");
        step("t5_in_reset", 1'b1, 4'd7, 1'b1);
        step("t5_in_reset", 1'b0, 4'd0, 1'b1);
        reset_ = 1'b1;

        // Periodic behaviour on the WRAP=1 instance.
        step("t6_load", 1'b1, 4'd2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step("t6", 1'b0, 4'd0, 1'b1);
            check("t6.q_seq", int'(q1), seq6[k]);
            check("t6.done_pulse", int'(done1), int'(seq6[k] == 0));
            check("t6.busy", int'(busy1), 1);
        end

        // Idle with Q=0 and T=0 gives no borrow.
        reset_ = 1'b0; model_reset();
        #1;
        T = 1'b0;
        #1;
        check("bout_t0", int'(bout0), 0);
        T = 1'b1;
        #1;
        check("bout_t1", int'(bout0), 1);
        reset_ = 1'b1;

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 logic'($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
